// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory-port arbiter:
//   arb_state_e      : arbiter FSM state encoding (IDLE, GNT_I, GNT_D)
//   W_BYTE/HALF/WORD : memory access width codes
//   DEFAULT_TIMEOUT  : default watchdog limit in grant cycles
//   DEFAULT_CNT_W    : default watchdog counter width
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    localparam int DEFAULT_TIMEOUT = 64;
    localparam int DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/mem_arb_watchdog.sv
// ---------------------------------------------------------------------------
// mem_arb_watchdog
// Counts grant cycles that pass without a memory acknowledge and flags the
// cycle in which the transfer has to be completed with an error.
//   clk     : clock
//   reset   : synchronous active-high reset, clears the count
//   clr_i   : clear the count (grant state is being entered or left)
//   en_i    : count this cycle (granted and no mem_ack)
//   tc_o    : terminal count - count == TIMEOUT-1 while enabled
// TIMEOUT = 0 disables tc_o. CNT_W must satisfy 2**CNT_W > TIMEOUT.
// ---------------------------------------------------------------------------
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic             WD_ON   = (TIMEOUT > 0);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_MAX)) begin
            // Saturate so a disabled or oversized limit can never wrap
            // back into a false terminal count.
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = WD_ON && en_i && (count_q == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between instruction fetch (I) and the mem-stage
// data requester (D). One transfer is outstanding at a time; D wins in IDLE,
// and under contention grants alternate because a completing requester is
// never re-granted directly. A watchdog completes a hung transfer with err.
//
// Handshake: a requester raises x_req with its address/controls and holds
// them until x_ack; x_ack is a single-cycle pulse with read data (and x_err
// on timeout) valid in that same cycle. Toward memory, mem_req follows the
// granted requester's req and mem_ack/mem_rdata complete it in one cycle.
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   i_req/i_addr -> i_ack/i_err/i_data          : fetch side (word reads)
//   d_req/d_addr/d_write/d_wdata/d_extend/d_width
//                -> d_ack/d_err/d_rdata          : data side
//   mem_req/mem_addr/mem_write/mem_wdata/mem_extend/mem_width : memory request
//   mem_ack/mem_rdata               : memory completion
//   busy                            : arbiter not IDLE
//   state_o                         : FSM state (debug)
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    // fetch requester
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_data,
    // data requester
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_write,
    input  logic [31:0] d_wdata,
    input  logic        d_extend,
    input  logic [1:0]  d_width,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    // memory port
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    output logic        mem_extend,
    output logic [1:0]  mem_width,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    // status
    output logic        busy,
    output arb_state_e  state_o
);

    arb_state_e state_q;
    arb_state_e state_d;

    logic wd_clr;
    logic wd_en;
    logic wd_tc;

    // The count restarts whenever the state changes, which covers both
    // IDLE->GNT and the back-to-back GNT_I<->GNT_D handover.
    assign wd_clr = (state_d != state_q);
    assign wd_en  = (state_q != IDLE) && !mem_ack;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clr_i (wd_clr),
        .en_i  (wd_en),
        .tc_o  (wd_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_write  = 1'b0;
        mem_wdata  = '0;
        mem_extend = 1'b0;
        mem_width  = W_BYTE;
        i_ack      = 1'b0;
        i_err      = 1'b0;
        i_data     = '0;
        d_ack      = 1'b0;
        d_err      = 1'b0;
        d_rdata    = '0;

        unique case (state_q)
            IDLE: begin
                // mem_ack arriving here is stray and deliberately ignored.
                if (d_req) begin
                    state_d = GNT_D;
                end else if (i_req) begin
                    state_d = GNT_I;
                end
            end

            GNT_I: begin
                mem_req   = i_req;
                mem_addr  = i_addr;
                mem_width = W_WORD;
                if (mem_ack) begin
                    // A real ack beats a simultaneous timeout.
                    i_ack   = 1'b1;
                    i_data  = mem_rdata;
                    state_d = d_req ? GNT_D : IDLE;
                end else if (wd_tc) begin
                    i_ack   = 1'b1;
                    i_err   = 1'b1;
                    state_d = IDLE;
                end
            end

            GNT_D: begin
                mem_req    = d_req;
                mem_addr   = d_addr;
                mem_write  = d_write;
                mem_wdata  = d_wdata;
                mem_extend = d_extend;
                mem_width  = d_width;
                if (mem_ack) begin
                    d_ack   = 1'b1;
                    d_rdata = mem_rdata;
                    state_d = i_req ? GNT_I : IDLE;
                end else if (wd_tc) begin
                    d_ack   = 1'b1;
                    d_err   = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A transfer aborted by reset must never report completion.
        if (reset) begin
            i_ack   = 1'b0;
            i_err   = 1'b0;
            i_data  = '0;
            d_ack   = 1'b0;
            d_err   = 1'b0;
            d_rdata = '0;
        end
    end

    assign busy    = (state_q != IDLE);
    assign state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter (TIMEOUT=4). Inputs change 1 ns after the
// rising edge and outputs are compared 1 ns later, well clear of the edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_data;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_write;
    logic [31:0] d_wdata;
    logic        d_extend;
    logic [1:0]  d_width;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic        mem_extend;
    logic [1:0]  mem_width;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    arb_state_e  state_o;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ack      (i_ack),
        .i_err      (i_err),
        .i_data     (i_data),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_write    (d_write),
        .d_wdata    (d_wdata),
        .d_extend   (d_extend),
        .d_width    (d_width),
        .d_ack      (d_ack),
        .d_err      (d_err),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_extend (mem_extend),
        .mem_width  (mem_width),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // A granted requester must keep its request up until the ack cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (state_o == GNT_I) assert (i_req) else $error("protocol: i_req dropped while granted");
            if (state_o == GNT_D) assert (d_req) else $error("protocol: d_req dropped while granted");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0; d_write = 1'b0; d_wdata = '0;
        d_extend = 1'b0; d_width = W_BYTE; mem_ack = 1'b0; mem_rdata = '0;

        // ---- reset state ----
        step(); step(); #1;
        check("rst_state", 32'(state_o), 32'(IDLE));
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_addr", mem_addr, 0);
        step(); reset = 1'b0;

        // ---- single fetch, memory acks two cycles after mem_req ----
        step(); i_req = 1'b1; i_addr = 32'h100; #1;
        check("f_c0_mem_req", 32'(mem_req), 0);
        step(); #1;
        check("f_c1_mem_req", 32'(mem_req), 1);
        check("f_c1_addr", mem_addr, 32'h100);
        check("f_c1_width", 32'(mem_width), 32'(W_WORD));
        check("f_c1_write", 32'(mem_write), 0);
        check("f_c1_i_ack", 32'(i_ack), 0);
        step(); #1;
        check("f_c2_i_ack", 32'(i_ack), 0);
        step(); mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
        check("f_c3_i_ack", 32'(i_ack), 1);
        check("f_c3_i_data", i_data, 32'hDEADBEEF);
        check("f_c3_i_err", 32'(i_err), 0);
        check("f_c3_d_ack", 32'(d_ack), 0);
        step(); mem_ack = 1'b0; mem_rdata = '0; i_req = 1'b0; #1;
        check("f_c4_state", 32'(state_o), 32'(IDLE));
        check("f_c4_busy", 32'(busy), 0);

        // ---- simultaneous: D store first, then I with no bubble ----
        step();
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_addr = 32'h200; d_write = 1'b1; d_wdata = 32'h12345678;
        d_width = W_BYTE; d_extend = 1'b0; #1;
        step(); #1;
        check("s_c1_state", 32'(state_o), 32'(GNT_D));
        check("s_c1_addr", mem_addr, 32'h200);
        check("s_c1_write", 32'(mem_write), 1);
        check("s_c1_width", 32'(mem_width), 32'(W_BYTE));
        check("s_c1_wdata", mem_wdata, 32'h12345678);
        step(); mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD; #1;
        check("s_c2_d_ack", 32'(d_ack), 1);
        check("s_c2_i_ack", 32'(i_ack), 0);
        check("s_c2_i_data", i_data, 0);
        step(); d_req = 1'b0; d_write = 1'b0; mem_rdata = 32'hCAFE0001; #1;
        check("s_c3_state", 32'(state_o), 32'(GNT_I));
        check("s_c3_mem_req", 32'(mem_req), 1);
        check("s_c3_addr", mem_addr, 32'h300);
        check("s_c3_write", 32'(mem_write), 0);
        check("s_c3_wdata", mem_wdata, 0);
        check("s_c3_i_ack", 32'(i_ack), 1);
        check("s_c3_i_data", i_data, 32'hCAFE0001);
        check("s_c3_d_ack", 32'(d_ack), 0);
        step(); mem_ack = 1'b0; i_req = 1'b0; #1;
        check("s_c4_state", 32'(state_o), 32'(IDLE));

        // ---- contention: both always requesting, 8 transfers D,I,D,I... ----
        step();
        i_req = 1'b1; i_addr = 32'h400;
        d_req = 1'b1; d_addr = 32'h500; d_write = 1'b0; d_extend = 1'b1; d_width = W_HALF; #1;
        for (int k = 0; k < 8; k++) begin
            step(); mem_ack = 1'b0; #1;
            if (k % 2 == 0) begin
                check("alt_state_d", 32'(state_o), 32'(GNT_D));
                check("alt_addr_d", mem_addr, 32'h500);
                check("alt_ext_d", 32'(mem_extend), 1);
                check("alt_width_d", 32'(mem_width), 32'(W_HALF));
            end else begin
                check("alt_state_i", 32'(state_o), 32'(GNT_I));
                check("alt_addr_i", mem_addr, 32'h400);
                check("alt_width_i", 32'(mem_width), 32'(W_WORD));
            end
            step(); mem_ack = 1'b1; mem_rdata = 32'h1000 + k;
            if (k == 7) d_req = 1'b0;
            #1;
            if (k % 2 == 0) begin
                check("alt_d_ack", 32'(d_ack), 1);
                check("alt_d_rdata", d_rdata, 32'h1000 + k);
                check("alt_i_ack_quiet", 32'(i_ack), 0);
            end else begin
                check("alt_i_ack", 32'(i_ack), 1);
                check("alt_i_data", i_data, 32'h1000 + k);
                check("alt_d_ack_quiet", 32'(d_ack), 0);
            end
        end
        step(); mem_ack = 1'b0; i_req = 1'b0; d_extend = 1'b0; #1;
        check("alt_end_state", 32'(state_o), 32'(IDLE));

        // ---- timeout: memory never acks, err in the 4th grant cycle ----
        step(); d_req = 1'b1; d_addr = 32'h600; d_width = W_WORD; mem_rdata = 32'hFFFFFFFF; #1;
        for (int c = 1; c <= 3; c++) begin
            step(); #1;
            check("to_wait_d_ack", 32'(d_ack), 0);
            check("to_wait_state", 32'(state_o), 32'(GNT_D));
        end
        step(); #1;
        check("to_d_ack", 32'(d_ack), 1);
        check("to_d_err", 32'(d_err), 1);
        check("to_d_rdata", d_rdata, 0);
        check("to_i_ack", 32'(i_ack), 0);
        step(); d_req = 1'b0; #1;
        check("to_next_state", 32'(state_o), 32'(IDLE));

        // ---- ack and timeout in the same cycle: normal completion ----
        step(); d_req = 1'b1; #1;
        for (int c = 1; c <= 3; c++) begin
            step(); #1;
            check("col_wait_d_ack", 32'(d_ack), 0);
        end
        step(); mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5; #1;
        check("col_d_ack", 32'(d_ack), 1);
        check("col_d_err", 32'(d_err), 0);
        check("col_d_rdata", d_rdata, 32'hA5A5A5A5);
        step(); mem_ack = 1'b0; d_req = 1'b0; #1;
        check("col_next_state", 32'(state_o), 32'(IDLE));

        // ---- reset in the 2nd GNT_I cycle, then a fresh fetch ----
        step(); i_req = 1'b1; i_addr = 32'h700; #1;
        step(); #1;
        check("rm_c1_mem_req", 32'(mem_req), 1);
        step(); reset = 1'b1; #1;
        check("rm_c2_i_ack", 32'(i_ack), 0);
        step(); reset = 1'b0; #1;
        check("rm_c3_mem_req", 32'(mem_req), 0);
        check("rm_c3_busy", 32'(busy), 0);
        check("rm_c3_i_ack", 32'(i_ack), 0);
        step(); #1;
        check("rm_c4_state", 32'(state_o), 32'(GNT_I));
        check("rm_c4_addr", mem_addr, 32'h700);
        step(); mem_ack = 1'b1; mem_rdata = 32'h77770000; #1;
        check("rm_c5_i_ack", 32'(i_ack), 1);
        check("rm_c5_i_data", i_data, 32'h77770000);
        step(); mem_ack = 1'b0; i_req = 1'b0; #1;
        check("rm_c6_state", 32'(state_o), 32'(IDLE));

        // ---- stray mem_ack in IDLE ----
        step(); mem_ack = 1'b1; mem_rdata = 32'h5555AAAA; #1;
        check("stray_i_ack", 32'(i_ack), 0);
        check("stray_d_ack", 32'(d_ack), 0);
        check("stray_i_data", i_data, 0);
        check("stray_busy", 32'(busy), 0);
        step(); mem_ack = 1'b0; #1;
        check("stray_state", 32'(state_o), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
